logic_seq0702: RTL and testbench

LOGIC_SEQ0702 -- requirements
Module: logic_seq0702

---
 rtl/guia07_pkg.sv | 30 +++
 rtl/logic_seq0702_step_counter.sv | 28 ++
 rtl/logic_seq0702.sv | 90 +++++++++
 tb/tb_logic_seq0702.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/guia07_pkg.sv
// Shared types and constants for the OR/NOR stimulus sequencer.
package guia07_pkg;

   localparam int unsigned STEPS_DEFAULT = 4;
   localparam int unsigned IDX_W         = 2;
   localparam int unsigned RES_W         = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      FINISH = 2'd3
   } state_t;

   typedef struct packed {
      logic x;
      logic y;
      logic s;
   } drive_t;

   // Vector i drives {x,y} = i and s = ~i[0], so s starts at 1 and alternates.
   function automatic drive_t drive_for(input logic [IDX_W-1:0] idx);
      drive_t d;
      d.x = idx[1];
      d.y = idx[0];
      d.s = ~idx[0];
      return d;
   endfunction

endpackage

// File: rtl/logic_seq0702_step_counter.sv
// Vector index counter: clear, increment, and terminal-count flag at STEPS-1.
module step_counter
   import guia07_pkg::*;
#(
   parameter int unsigned STEPS = STEPS_DEFAULT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             inc,
   output logic [IDX_W-1:0] idx,
   output logic             last_c
);

   assign last_c = (idx == IDX_W'(STEPS - 1));

   // Increment is gated by the terminal flag so the index never wraps within a run.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx <= '0;
      end else if (clr) begin
         idx <= '0;
      end else if (inc && !last_c) begin
         idx <= idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/logic_seq0702.sv
// Drives STEPS (x,y,s) vectors to a downstream OR/NOR stage and captures each z_in reply.
module logic_seq0702
   import guia07_pkg::*;
#(
   parameter int unsigned STEPS = STEPS_DEFAULT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             step_en,
   input  logic             z_in,
   output logic             x,
   output logic             y,
   output logic             s,
   output logic             busy,
   output logic             done,
   output logic [RES_W-1:0] result
);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic             last_c;
   logic             cnt_clr_c;
   logic             cnt_inc_c;
   drive_t           nxt_vec_c;

   assign cnt_clr_c = (state == IDLE) && start;
   assign cnt_inc_c = (state == SAMPLE) && !last_c;
   assign nxt_vec_c = drive_for(idx + IDX_W'(1));

   step_counter #(
      .STEPS (STEPS)
   ) u_step_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (cnt_clr_c),
      .inc     (cnt_inc_c),
      .idx     (idx),
      .last_c  (last_c)
   );

   // Outputs are loaded on the edge that enters each state so they track the index.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         x      <= 1'b0;
         y      <= 1'b0;
         s      <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= DRIVE;
                  busy      <= 1'b1;
                  result    <= '0;
                  {x, y, s} <= drive_for('0);
               end
            end
            DRIVE: begin
               if (step_en) begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               result[idx] <= z_in;
               if (last_c) begin
                  state     <= FINISH;
                  done      <= 1'b1;
                  {x, y, s} <= 3'b000;
               end else begin
                  state     <= DRIVE;
                  {x, y, s} <= nxt_vec_c;
               end
            end
            FINISH: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_logic_seq0702.sv
// Directed bench for logic_seq0702 with an OR/NOR mux model on z_in.
module tb_logic_seq0702;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic       step_en;
   logic       z_in;
   logic       x, y, s, busy, done;
   logic [3:0] result;
   logic [1:0] zmode;

   logic       start2;
   logic       z2;
   logic       x2, y2, s2, busy2, done2;
   logic [3:0] result2;

   logic [2:0] xys;
   logic [2:0] vec_tbl [4] = '{3'b001, 3'b010, 3'b101, 3'b110};

   int checks      = 0;
   int failures    = 0;
   int busy_total  = 0;
   int done_total  = 0;

   assign xys  = {x, y, s};
   assign z_in = (zmode == 2'd1) ? 1'b1 :
                 (zmode == 2'd2) ? 1'b0 : (s ? (x | y) : ~(x | y));
   assign z2   = s2 ? (x2 | y2) : ~(x2 | y2);

   logic_seq0702 #(.STEPS(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .step_en (step_en),
      .z_in    (z_in),
      .x       (x),
      .y       (y),
      .s       (s),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   logic_seq0702 #(.STEPS(2)) dut2 (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start2),
      .step_en (1'b1),
      .z_in    (z2),
      .x       (x2),
      .y       (y2),
      .s       (s2),
      .busy    (busy2),
      .done    (done2),
      .result  (result2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (busy) busy_total <= busy_total + 1;
      if (done) done_total <= done_total + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One run of dut: optional stall window and optional start re-pulse while busy.
   task automatic run(input string tag, input logic [3:0] exp_res, input int exp_edge,
                      input int stall_edge, input int stall_len, input int repulse_at);
      int n, b0, d0;
      b0 = busy_total;
      d0 = done_total;
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      check({tag, ".accept_busy"}, 32'(busy), 32'd1);
      check({tag, ".clear"}, 32'(result), 32'd0);
      check({tag, ".vec0"}, 32'(xys), 32'(vec_tbl[0]));
      while (!done && n < 40) begin
         if (stall_len > 0 && n == stall_edge) step_en = 1'b0;
         if (stall_len > 0 && n == stall_edge + stall_len) step_en = 1'b1;
         start = (n == repulse_at);
         step();
         n++;
         if (stall_len > 0 && n > stall_edge && n <= stall_edge + stall_len)
            check({tag, ".hold"}, 32'(xys), 32'(vec_tbl[2]));
         if (stall_len == 0 && n % 2 == 0 && n < exp_edge)
            check({tag, ".seq"}, 32'(xys), 32'(vec_tbl[n / 2]));
      end
      start   = 1'b0;
      step_en = 1'b1;
      check({tag, ".done_edge"}, 32'(n), 32'(exp_edge));
      check({tag, ".finish_xys"}, 32'(xys), 32'd0);
      step();
      check({tag, ".done_low"}, 32'(done), 32'd0);
      check({tag, ".idle_busy"}, 32'(busy), 32'd0);
      check({tag, ".result"}, 32'(result), 32'(exp_res));
      check({tag, ".busy_cycles"}, 32'(busy_total - b0), 32'(exp_edge + 1));
      check({tag, ".done_pulses"}, 32'(done_total - d0), 32'd1);
   endtask

   initial begin
      int n, d0;
      reset_n = 1'b0;
      start   = 1'b0;
      start2  = 1'b0;
      step_en = 1'b1;
      zmode   = 2'd0;

      #12;
      check("rst.xys", 32'(xys), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.result", 32'(result), 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      step();

      run("mux", 4'b0100, 8, -1, 0, -1);
      repeat (3) step();
      check("idle_hold.result", 32'(result), 32'h4);

      zmode = 2'd1;
      run("tie1", 4'b1111, 8, -1, 0, -1);
      zmode = 2'd2;
      run("tie0", 4'b0000, 8, -1, 0, -1);
      zmode = 2'd0;

      run("stall", 4'b0100, 11, 4, 3, -1);
      run("restart", 4'b0100, 8, -1, 0, 3);

      // Abort in SAMPLE with i=1: reset acts before the next edge.
      d0 = done_total;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      check("abort.pre_xys", 32'(xys), 32'(vec_tbl[1]));
      #2 reset_n = 1'b0;
      #1;
      check("abort.xys", 32'(xys), 32'd0);
      check("abort.busy", 32'(busy), 32'd0);
      check("abort.done", 32'(done), 32'd0);
      check("abort.result", 32'(result), 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (2) step();
      check("abort.no_done", 32'(done_total - d0), 32'd0);
      run("after_rst", 4'b0100, 8, -1, 0, -1);

      // STEPS=2 instance.
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      n = 0;
      while (!done2 && n < 40) begin
         step();
         n++;
      end
      check("steps2.done_edge", 32'(n), 32'd4);
      step();
      check("steps2.result", 32'(result2), 32'd0);
      check("steps2.busy", 32'(busy2), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
